// File: rtl/vm2002_change_dispenser.sv
// ============================================================================
// Module  : vm2002_change_dispenser
// Brief   : Greedy change payout (quarter/dime/nickel) over a valid/ack coin
//           hopper handshake, with refillable coin tubes.
//           Optional macro VM2002_CHANGE_STATS_EN adds change_paid_total.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vm2002_change_dispenser #(
  parameter int TUBE_MAX = 15,
  parameter int AMT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             change_req,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             restock,
  input  logic             coin_in_valid,
  input  logic [1:0]       coin_in,
  output logic             coin_out_valid,
  output logic [1:0]       coin_out,
  input  logic             coin_out_ack,
  output logic             change_busy,
  output logic             change_done,
  output logic             change_short,
  output logic [AMT_W-1:0] change_owed,
  output logic             coin_overflow,
`ifdef VM2002_CHANGE_STATS_EN
  output logic [15:0]      change_paid_total,
`endif
  output logic [3:0]       nickel_cnt,
  output logic [3:0]       dime_cnt,
  output logic [3:0]       quarter_cnt
);

  localparam logic [1:0] c_coin_none    = 2'b00;
  localparam logic [1:0] c_coin_nickel  = 2'b01;
  localparam logic [1:0] c_coin_dime    = 2'b10;
  localparam logic [1:0] c_coin_quarter = 2'b11;
  localparam logic [3:0] c_tube_max     = 4'(TUBE_MAX);

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0001,
    S_SELECT = 4'b0010,
    S_ISSUE  = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AMT_W-1:0] r_remaining;
  logic [2:0]       r_residue;
  logic             r_short;
  logic [1:0]       r_coin;
  logic [3:0]       r_nickel, r_dime, r_quarter;
  logic             r_overflow;

  logic [1:0]       w_sel_coin;
  logic             w_short;
  logic             w_req, w_restock, w_ack, w_in_valid, w_ovf;
  logic [2:0]       w_residue;
  logic [AMT_W-1:0] w_coin_val;
  logic [4:0]       w_nickel_nxt, w_dime_nxt, w_quarter_nxt;

  // Returns {overflow, next_level}; a simultaneous in/out on one tube nets to zero.
  function automatic logic [4:0] tube_next(input logic [3:0] lvl, input logic inc, input logic dec);
    if (inc && !dec)
      tube_next = (lvl >= c_tube_max) ? {1'b1, lvl} : {1'b0, lvl + 4'd1};
    else if (dec && !inc)
      tube_next = {1'b0, lvl - 4'd1};
    else
      tube_next = {1'b0, lvl};
  endfunction

  assign w_req      = (r_state == S_IDLE) && change_req;
  assign w_restock  = (r_state == S_IDLE) && restock;
  assign w_ack      = (r_state == S_ISSUE) && coin_out_ack;
  assign w_in_valid = coin_in_valid && (coin_in != c_coin_none);
  assign w_residue  = 3'(change_amt % AMT_W'(5));

  always_comb begin
    w_coin_val = '0;
    case (r_coin)
      c_coin_nickel:  w_coin_val = AMT_W'(5);
      c_coin_dime:    w_coin_val = AMT_W'(10);
      c_coin_quarter: w_coin_val = AMT_W'(25);
      default:        w_coin_val = '0;
    endcase
  end

  assign w_nickel_nxt  = tube_next(r_nickel,  w_in_valid && coin_in == c_coin_nickel,
                                   w_ack && r_coin == c_coin_nickel);
  assign w_dime_nxt    = tube_next(r_dime,    w_in_valid && coin_in == c_coin_dime,
                                   w_ack && r_coin == c_coin_dime);
  assign w_quarter_nxt = tube_next(r_quarter, w_in_valid && coin_in == c_coin_quarter,
                                   w_ack && r_coin == c_coin_quarter);
  // A restock fills every tube, so any coin offered alongside it goes to the cash box.
  assign w_ovf = w_restock ? w_in_valid
                           : (w_nickel_nxt[4] | w_dime_nxt[4] | w_quarter_nxt[4]);

  always_comb begin
    w_state_nxt = r_state;
    w_sel_coin  = c_coin_none;
    w_short     = 1'b0;
    case (r_state)
      S_IDLE:   if (change_req) w_state_nxt = S_SELECT;
      S_SELECT: begin
        if (r_remaining == '0) begin
          w_state_nxt = S_DONE;
        end else if (r_remaining >= AMT_W'(25) && r_quarter != '0) begin
          w_state_nxt = S_ISSUE;
          w_sel_coin  = c_coin_quarter;
        end else if (r_remaining >= AMT_W'(10) && r_dime != '0) begin
          w_state_nxt = S_ISSUE;
          w_sel_coin  = c_coin_dime;
        end else if (r_remaining >= AMT_W'(5) && r_nickel != '0) begin
          w_state_nxt = S_ISSUE;
          w_sel_coin  = c_coin_nickel;
        end else begin
          w_state_nxt = S_DONE;
          w_short     = 1'b1;
        end
      end
      S_ISSUE:  if (coin_out_ack) w_state_nxt = S_SELECT;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_residue   <= '0;
      r_short     <= 1'b0;
      r_coin      <= c_coin_none;
      r_nickel    <= '0;
      r_dime      <= '0;
      r_quarter   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_overflow <= w_ovf;
      if (w_restock) begin
        r_nickel  <= c_tube_max;
        r_dime    <= c_tube_max;
        r_quarter <= c_tube_max;
      end else begin
        r_nickel  <= w_nickel_nxt[3:0];
        r_dime    <= w_dime_nxt[3:0];
        r_quarter <= w_quarter_nxt[3:0];
      end
      if (w_req) begin
        r_remaining <= change_amt - AMT_W'(w_residue);
        r_residue   <= w_residue;
        r_short     <= 1'b0;
      end else if (w_ack) begin
        r_remaining <= r_remaining - w_coin_val;
      end
      if (r_state == S_SELECT) begin
        r_coin <= w_sel_coin;
        if (w_short) r_short <= 1'b1;
      end
    end
  end

`ifdef VM2002_CHANGE_STATS_EN
  logic [15:0] r_paid_total;
  logic [16:0] w_paid_sum;

  assign w_paid_sum = {1'b0, r_paid_total} + 17'(w_coin_val);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_paid_total <= '0;
    else if (w_ack)
      r_paid_total <= w_paid_sum[16] ? 16'hFFFF : w_paid_sum[15:0];
  end

  assign change_paid_total = r_paid_total;
`endif

  assign coin_out_valid = (r_state == S_ISSUE);
  assign coin_out       = coin_out_valid ? r_coin : c_coin_none;
  assign change_busy    = (r_state != S_IDLE);
  assign change_done    = (r_state == S_DONE);
  assign change_short   = change_done && r_short;
  assign change_owed    = change_done ? (r_remaining + AMT_W'(r_residue)) : '0;
  assign coin_overflow  = r_overflow;
  assign nickel_cnt     = r_nickel;
  assign dime_cnt       = r_dime;
  assign quarter_cnt    = r_quarter;

endmodule

`default_nettype wire

// File: tb/tb_vm2002_change_dispenser.sv
// ============================================================================
// Module  : tb_vm2002_change_dispenser
// Brief   : Scoreboard bench: stimulus queues expected coins/done results, a
//           monitor pops and compares them as the DUT presents them.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vm2002_change_dispenser;

  logic       clock = 1'b0;
  logic       reset;
  logic       change_req;
  logic [7:0] change_amt;
  logic       restock;
  logic       coin_in_valid;
  logic [1:0] coin_in;
  logic       coin_out_valid;
  logic [1:0] coin_out;
  logic       coin_out_ack = 1'b0;
  logic       change_busy;
  logic       change_done;
  logic       change_short;
  logic [7:0] change_owed;
  logic       coin_overflow;
  logic [3:0] nickel_cnt, dime_cnt, quarter_cnt;
`ifdef VM2002_CHANGE_STATS_EN
  logic [15:0] change_paid_total;
`endif

  vm2002_change_dispenser #(.TUBE_MAX(15), .AMT_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .change_req     (change_req),
    .change_amt     (change_amt),
    .restock        (restock),
    .coin_in_valid  (coin_in_valid),
    .coin_in        (coin_in),
    .coin_out_valid (coin_out_valid),
    .coin_out       (coin_out),
    .coin_out_ack   (coin_out_ack),
    .change_busy    (change_busy),
    .change_done    (change_done),
    .change_short   (change_short),
    .change_owed    (change_owed),
    .coin_overflow  (coin_overflow),
`ifdef VM2002_CHANGE_STATS_EN
    .change_paid_total (change_paid_total),
`endif
    .nickel_cnt     (nickel_cnt),
    .dime_cnt       (dime_cnt),
    .quarter_cnt    (quarter_cnt)
  );

  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;
  int exp_coin_q[$];
  int exp_done_q[$];   // short*1000 + owed
  int n_done  = 0;
  int n_ovf   = 0;
  int exp_n_done = 0;
  logic prev_cov = 1'b0;
  logic hop_en   = 1'b0;
  int   hop_wait = 2;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Hopper model: acks each offered coin after a fixed wait.
  always @(negedge clock) begin
    if (hop_en && coin_out_valid && !coin_out_ack) begin
      if (hop_wait > 0) hop_wait--;
      else coin_out_ack = 1'b1;
    end else begin
      coin_out_ack = 1'b0;
      hop_wait     = 2;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      prev_cov = 1'b0;
    end else begin
      if (coin_out_valid && !prev_cov) begin
        check("coin_expected", int'(exp_coin_q.size() != 0), 1);
        if (exp_coin_q.size() != 0) check("coin_out", int'(coin_out), exp_coin_q.pop_front());
      end
      prev_cov = coin_out_valid;
      if (change_done) begin
        n_done++;
        check("done_expected", int'(exp_done_q.size() != 0), 1);
        if (exp_done_q.size() != 0)
          check("done_short_owed", int'(change_short) * 1000 + int'(change_owed), exp_done_q.pop_front());
      end
      if (coin_overflow) n_ovf++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask

  task automatic do_restock();
    restock = 1'b1;
    step();
    restock = 1'b0;
  endtask

  task automatic req(input int amt);
    change_req = 1'b1;
    change_amt = 8'(amt);
    step();
    change_req = 1'b0;
  endtask

  task automatic give_coin(input logic [1:0] c);
    coin_in_valid = 1'b1;
    coin_in       = c;
    step();
    coin_in_valid = 1'b0;
    coin_in       = 2'b00;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    exp_n_done++;
    while (n_done < exp_n_done && k < budget) begin
      step();
      k++;
    end
    check("done_arrived", int'(n_done >= exp_n_done), 1);
  endtask

  task automatic check_tubes(input string name, input int n, input int d, input int q);
    check({name, "_nickel"},  int'(nickel_cnt),  n);
    check({name, "_dime"},    int'(dime_cnt),    d);
    check({name, "_quarter"}, int'(quarter_cnt), q);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_cov"},   int'(coin_out_valid), 0);
    check({name, "_cout"},  int'(coin_out),       0);
    check({name, "_busy"},  int'(change_busy),    0);
    check({name, "_done"},  int'(change_done),    0);
    check({name, "_short"}, int'(change_short),   0);
    check({name, "_owed"},  int'(change_owed),    0);
    check({name, "_ovf"},   int'(coin_overflow),  0);
    check_tubes(name, 0, 0, 0);
  endtask

  initial begin
    int k;
    int ovf0;
    reset = 1'b1; change_req = 1'b0; change_amt = '0; restock = 1'b0;
    coin_in_valid = 1'b0; coin_in = 2'b00;
    step(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    step();
    hop_en = 1'b1;

    // T1: 40 cents -> quarter, dime, nickel
    do_restock();
    check_tubes("restock", 15, 15, 15);
    exp_coin_q.push_back(3); exp_coin_q.push_back(2); exp_coin_q.push_back(1);
    exp_done_q.push_back(0);
    req(40);
    check("lat_select_cov", int'(coin_out_valid), 0);
    check("lat_select_busy", int'(change_busy), 1);
    step();
    check("lat_issue_cov", int'(coin_out_valid), 1);
    wait_done(200);
    step(2);
    check_tubes("t1", 14, 14, 14);
`ifdef VM2002_CHANGE_STATS_EN
    check("paid_total", int'(change_paid_total), 40);
`endif

    // Zero amount: done two cycles after the request
    exp_done_q.push_back(0);
    req(0);
    step();
    check("zero_done_lat", int'(change_done), 1);
    wait_done(20);
    step();

    // T2: no quarters left, 30 cents -> three dimes
    do_restock();
    for (int i = 0; i < 15; i++) begin
      exp_coin_q.push_back(3);
      exp_done_q.push_back(0);
      req(25);
      wait_done(50);
      step();
    end
    check("t2_quarters_drained", int'(quarter_cnt), 0);
    for (int i = 0; i < 3; i++) exp_coin_q.push_back(2);
    exp_done_q.push_back(0);
    req(30);
    wait_done(200);
    step();
    check_tubes("t2", 15, 12, 0);

    // T3: empty tubes plus one nickel, 12 cents -> short with 7 owed
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_tubes("t3_reset", 0, 0, 0);
    give_coin(2'b01);
    step();
    check("t3_nickel_in", int'(nickel_cnt), 1);
    exp_coin_q.push_back(1);
    exp_done_q.push_back(1007);
    req(12);
    wait_done(100);
    step();
    check("t3_nickel_out", int'(nickel_cnt), 0);

    // T4: quarter refilled in the ack cycle of a full quarter tube
    do_restock();
    ovf0 = n_ovf;
    exp_coin_q.push_back(3);
    exp_done_q.push_back(0);
    req(25);
    k = 0;
    while (!coin_out_ack && k < 50) begin
      step();
      k++;
    end
    check("t4_ack_seen", int'(coin_out_ack), 1);
    coin_in_valid = 1'b1;
    coin_in       = 2'b11;
    step();
    coin_in_valid = 1'b0;
    coin_in       = 2'b00;
    wait_done(50);
    step(2);
    check("t4_quarter_level", int'(quarter_cnt), 15);
    check("t4_no_overflow", n_ovf - ovf0, 0);

    // T5: overflow cases, invalid coin, requests and restock while busy
    do_restock();
    ovf0 = n_ovf;
    give_coin(2'b10);
    step();
    check("t5_dime_overflow", n_ovf - ovf0, 1);
    check("t5_dime_level", int'(dime_cnt), 15);
    give_coin(2'b00);
    step();
    check("t5_invalid_coin", n_ovf - ovf0, 1);
    restock = 1'b1; coin_in_valid = 1'b1; coin_in = 2'b01;
    step();
    restock = 1'b0; coin_in_valid = 1'b0; coin_in = 2'b00;
    step();
    check("t5_restock_overflow", n_ovf - ovf0, 2);
    check("t5_restock_nickel", int'(nickel_cnt), 15);
    exp_coin_q.push_back(2);
    exp_done_q.push_back(0);
    req(10);
    step();
    req(40);
    do_restock();
    wait_done(50);
    step(8);
    check("t5_single_done", n_done, exp_n_done);
    check("t5_restock_ignored", int'(dime_cnt), 14);

    // T6: reset while a coin is being offered
    hop_en = 1'b0;
    exp_coin_q.push_back(3);
    req(50);
    k = 0;
    while (!coin_out_valid && k < 20) begin
      step();
      k++;
    end
    check("t6_cov_seen", int'(coin_out_valid), 1);
    reset = 1'b1;
    #1;
    check_idle_outputs("t6_async");
    step(2);
    reset = 1'b0;
    step(5);
    check("t6_no_done", n_done, exp_n_done);
    check("t6_idle", int'(change_busy), 0);

    check("coin_q_empty", exp_coin_q.size(), 0);
    check("done_q_empty", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
